// File: rtl/c5x7_pkg.sv
// ============================================================================
// c5x7_pkg : shared sizes, sample type and window indexing for the c5x7 path
// Rev 1.0  : initial release
// ============================================================================
`default_nettype none

package c5x7_pkg;

    localparam int DW = 40;
    localparam int KR = 7;
    localparam int KC = 5;

    typedef logic signed [DW-1:0] sample_t;

    // Flattened window slot for row r, column c (row 0 = oldest line)
    function automatic int widx(input int r, input int c);
        return r * KC + c;
    endfunction

endpackage

`default_nettype wire

// File: rtl/c5x7_linebuf.sv
// ============================================================================
// c5x7_linebuf : IMG_W-deep, multi-lane line store sharing one column address
// Rev 1.0      : initial release
// ============================================================================
`default_nettype none

module c5x7_linebuf #(
    parameter int DW    = 40,
    parameter int DEPTH = 64,
    parameter int LANES = 6
) (
    input  logic                      clk,
    input  logic                      i_we,
    input  logic [$clog2(DEPTH)-1:0]  i_addr,
    input  logic [DW-1:0]             i_din,
    output logic [LANES*DW-1:0]       o_col
);

    logic [LANES*DW-1:0] r_mem [DEPTH];

    // Asynchronous read gives the pre-write column for a same-address write
    assign o_col = r_mem[i_addr];

    // Each lane ages by one line; the newest sample enters lane 0
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= {o_col[(LANES-1)*DW-1:0], i_din};
        end
    end

endmodule

`default_nettype wire

// File: rtl/c5x7_window_gen.sv
// ============================================================================
// c5x7_window_gen : raster stream to 7x5 sample window feeder for c5x7 core
// Rev 1.0         : initial release
// ============================================================================
`default_nettype none

module c5x7_window_gen #(
    parameter int DW    = c5x7_pkg::DW,
    parameter int IMG_W = 64,
    parameter int IMG_H = 64
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   in_valid,
    input  logic                                   in_sof,
    input  logic [DW-1:0]                          in_data,
    output logic                                   push_samp,
    output logic [c5x7_pkg::KR*c5x7_pkg::KC*DW-1:0] win,
    output logic                                   frame_done
);

    import c5x7_pkg::*;

    localparam int XW    = $clog2(IMG_W);
    localparam int YW    = $clog2(IMG_H);
    localparam int LANES = KR - 1;

    localparam logic [XW-1:0] c_X_LAST = XW'(IMG_W - 1);
    localparam logic [YW-1:0] c_Y_LAST = YW'(IMG_H - 1);
    localparam logic [XW-1:0] c_X_WIN  = XW'(KC - 1);
    localparam logic [YW-1:0] c_Y_WIN  = YW'(KR - 1);

    logic [XW-1:0]          r_x;
    logic [YW-1:0]          r_y;
    logic                   r_push;
    logic                   r_fd;
    logic [KR*KC*DW-1:0]    r_win;

    logic [XW-1:0]          w_x;
    logic [YW-1:0]          w_y;
    logic                   w_x_last;
    logic                   w_y_last;
    logic                   w_we;
    logic [LANES*DW-1:0]    w_col;

    // Start-of-frame forces the current pixel to (0,0) whatever the counters say
    always_comb begin
        w_x      = in_sof ? '0 : r_x;
        w_y      = in_sof ? '0 : r_y;
        w_x_last = (w_x == c_X_LAST);
        w_y_last = (w_y == c_Y_LAST);
        w_we     = in_valid & reset;
    end

    c5x7_linebuf #(
        .DW    (DW),
        .DEPTH (IMG_W),
        .LANES (LANES)
    ) u_linebuf (
        .clk    (clk),
        .i_we   (w_we),
        .i_addr (w_x),
        .i_din  (in_data),
        .o_col  (w_col)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_x    <= '0;
            r_y    <= '0;
            r_push <= 1'b0;
            r_fd   <= 1'b0;
            r_win  <= '0;
        end else begin
            r_push <= 1'b0;
            r_fd   <= 1'b0;
            if (in_valid) begin
                r_x <= w_x_last ? '0 : w_x + XW'(1);
                r_y <= w_x_last ? (w_y_last ? '0 : w_y + YW'(1)) : w_y;
                // Gating on both counters keeps windows inside one line and
                // hides stale line-buffer contents after reset or abort
                r_push <= (w_x >= c_X_WIN) && (w_y >= c_Y_WIN);
                r_fd   <= w_x_last && w_y_last;
                for (int r = 0; r < KR; r++) begin
                    for (int c = 0; c < KC - 1; c++) begin
                        r_win[widx(r, c)*DW +: DW] <= r_win[widx(r, c + 1)*DW +: DW];
                    end
                end
                // Row r takes the line that is (KR-1-r) lines old
                for (int r = 0; r < KR - 1; r++) begin
                    r_win[widx(r, KC - 1)*DW +: DW] <= w_col[(LANES - 1 - r)*DW +: DW];
                end
                r_win[widx(KR - 1, KC - 1)*DW +: DW] <= in_data;
            end
        end
    end

    assign push_samp  = r_push;
    assign frame_done = r_fd;
    assign win        = r_win;

endmodule

`default_nettype wire

// File: tb/tb_c5x7_window_gen.sv
// ============================================================================
// tb_c5x7_window_gen : scoreboard bench for the c5x7 window generator
// Rev 1.0            : initial release
// ============================================================================
`default_nettype none

module tb_c5x7_window_gen;

    import c5x7_pkg::*;

    localparam int W  = 8;
    localparam int H  = 8;
    localparam int WB = KR * KC * DW;

    logic            clk = 1'b0;
    logic            reset;
    logic            in_valid;
    logic            in_sof;
    logic [DW-1:0]   in_data;
    logic            push_samp;
    logic            frame_done;
    logic [WB-1:0]   win;

    always #5 clk = ~clk;

    c5x7_window_gen #(
        .DW    (DW),
        .IMG_W (W),
        .IMG_H (H)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_sof     (in_sof),
        .in_data    (in_data),
        .push_samp  (push_samp),
        .win        (win),
        .frame_done (frame_done)
    );

    typedef struct {
        logic [WB-1:0] w;
        logic          fd;
    } exp_t;

    exp_t          sbq[$];
    int            n_vec  = 0;
    int            n_err  = 0;
    int            npush  = 0;
    int            tcase  = 0;
    bit            mon_en = 1'b0;
    logic          edge_chg = 1'b1;
    logic          edge_acc = 1'b0;
    logic [WB-1:0] prev_win;
    sample_t       img [H][W];
    int            mx = 0;
    int            my = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [63:0] samp(input logic [WB-1:0] w, input int r, input int c);
        return 64'(w[widx(r, c)*DW +: DW]);
    endfunction

    // Apply one cycle of input; the reference model records the pixel in a
    // frame image and predicts the window straight from image coordinates
    task automatic drive(input logic v, input logic s, input sample_t d);
        int   ex;
        int   ey;
        exp_t e;
        in_valid = v;
        in_sof   = s;
        in_data  = d;
        if (v) begin
            ex = s ? 0 : mx;
            ey = s ? 0 : my;
            img[ey][ex] = d;
            if (ex >= KC - 1 && ey >= KR - 1) begin
                e.w = '0;
                for (int r = 0; r < KR; r++)
                    for (int c = 0; c < KC; c++)
                        e.w[(r*KC + c)*DW +: DW] = img[ey - (KR - 1) + r][ex - (KC - 1) + c];
                e.fd = (ex == W - 1) && (ey == H - 1);
                sbq.push_back(e);
            end
            if (ex == W - 1) begin
                mx = 0;
                my = (ey == H - 1) ? 0 : ey + 1;
            end else begin
                mx = ex + 1;
                my = ey;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 1'b0, sample_t'({$urandom, $urandom}));
    endtask

    // Raster feed; stops just before (sx,sy) when that point lies in the frame
    task automatic feed(input sample_t base, input int gap, input int sx, input int sy);
        for (int y = 0; y < H; y++) begin
            for (int x = 0; x < W; x++) begin
                if (x == sx && y == sy) return;
                while (int'($urandom_range(99)) < gap) idle(1);
                drive(1'b1, (x == 0 && y == 0), base + sample_t'((y << 4) | x));
            end
        end
    endtask

    task automatic reset_pulse();
        reset    = 1'b0;
        in_valid = 1'b1;
        in_sof   = 1'b0;
        in_data  = '1;
        @(posedge clk);
        #1;
        reset    = 1'b1;
        in_valid = 1'b0;
        mx = 0;
        my = 0;
        @(negedge clk);
        chk("rst_push", push_samp, 0);
        chk("rst_fd", frame_done, 0);
        chk("rst_win_nonzero", |win, 0);
        @(posedge clk);
        #1;
    endtask

    always @(posedge clk) begin
        edge_chg <= in_valid || !reset;
        edge_acc <= in_valid && reset;
    end

    always @(negedge clk) begin
        if (mon_en) begin
            if (push_samp) begin
                exp_t e;
                npush++;
                chk("push_without_accept", edge_acc, 1);
                chk("sb_nonempty", sbq.size() != 0, 1);
                if (sbq.size() != 0) begin
                    e = sbq.pop_front();
                    for (int r = 0; r < KR; r++)
                        for (int c = 0; c < KC; c++)
                            chk($sformatf("win_s%0d%0d", r, c), samp(win, r, c), samp(e.w, r, c));
                    chk("frame_done", frame_done, e.fd);
                end
                if (tcase == 1 && npush == 1) begin
                    chk("t1_samp00", samp(win, 0, 0), 64'h00);
                    chk("t1_samp04", samp(win, 0, 4), 64'h04);
                    chk("t1_samp60", samp(win, 6, 0), 64'h60);
                    chk("t1_samp64", samp(win, 6, 4), 64'h64);
                    chk("t1_samp32", samp(win, 3, 2), 64'h32);
                end
                if (frame_done && tcase <= 2)
                    chk("last_samp64", samp(win, 6, 4), 64'h77);
                if (tcase == 3 && npush == 9)
                    chk("t3_samp00", samp(win, 0, 0), 64'h100);
            end else begin
                chk("fd_without_push", frame_done, 0);
            end
            if (!edge_chg) begin
                for (int i = 0; i < KR * KC; i++)
                    chk("win_hold", 64'(win[i*DW +: DW]), 64'(prev_win[i*DW +: DW]));
            end
            prev_win = win;
        end
    end

    initial begin
        reset    = 1'b0;
        in_valid = 1'b0;
        in_sof   = 1'b0;
        in_data  = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("init_push", push_samp, 0);
        chk("init_fd", frame_done, 0);
        chk("init_win_nonzero", |win, 0);
        prev_win = win;
        mon_en   = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b1;
        idle(2);

        tcase = 1; npush = 0;
        feed(sample_t'(0), 0, -1, -1);
        idle(3);
        chk("t1_pushes", npush, 8);
        chk("t1_sb_left", sbq.size(), 0);

        tcase = 2; npush = 0;
        feed(sample_t'(0), 40, -1, -1);
        idle(3);
        chk("t2_pushes", npush, 8);
        chk("t2_sb_left", sbq.size(), 0);

        tcase = 3; npush = 0;
        feed(sample_t'(0), 0, -1, -1);
        feed(sample_t'(40'h100), 0, -1, -1);
        idle(3);
        chk("t3_pushes", npush, 16);
        chk("t3_sb_left", sbq.size(), 0);

        tcase = 4; npush = 0;
        feed(sample_t'(40'h200), 0, 3, 5);
        feed(sample_t'(0), 0, -1, -1);
        idle(3);
        chk("t4_pushes", npush, 8);
        chk("t4_sb_left", sbq.size(), 0);

        tcase = 5; npush = 0;
        feed(sample_t'(40'h300), 0, 5, 7);
        reset_pulse();
        chk("t5_sb_after_rst", sbq.size(), 0);
        feed(sample_t'(0), 0, -1, -1);
        idle(3);
        chk("t5_pushes", npush, 13);
        chk("t5_sb_left", sbq.size(), 0);

        tcase = 6; npush = 0;
        feed(sample_t'(40'h80_0000_0000), 30, -1, -1);
        idle(3);
        chk("t6_pushes", npush, 8);
        chk("t6_sb_left", sbq.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
